fir_coeff_loader: RTL

Sequencer that owns run-time reconfiguration of the three-axis 16-tap FIR signal path. It accepts a load command from the host side, then streams one bank of coefficients into the signal path's `update_*` write port, one write per cycle. It optionally switches the axis's active bank (`x_bank`/`y_bank`/`z_bank`) to the freshly loaded one, doing so only while the signal path reports `available`. Writes to the bank currently in use are refused, so the filter never sees a half-written coefficient set.

---
 rtl/fir_coeff_loader_if.sv | 39 +++
 rtl/fir_coeff_loader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_loader_if.sv
// Bundles the host command channel, the coefficient stream and the signal
// path's coefficient write port.
// master: host side plus signal path (drives commands and coefficients,
//         receives the write port).
// slave:  the loader.
interface fir_coeff_loader_if #(
    parameter int COEFF_W = 16,
    parameter int IDX_W   = 4
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_axis;
    logic [1:0]         cmd_bank;
    logic               cmd_activate;

    logic               coeff_valid;
    logic               coeff_ready;
    logic [COEFF_W-1:0] coeff_data;

    logic               update_en;
    logic [1:0]         update_axis;
    logic [1:0]         update_bank;
    logic [IDX_W-1:0]   update_index;
    logic [COEFF_W-1:0] update_value;

    modport master (
        output cmd_valid, cmd_axis, cmd_bank, cmd_activate,
        output coeff_valid, coeff_data,
        input  cmd_ready, coeff_ready,
        input  update_en, update_axis, update_bank, update_index, update_value
    );

    modport slave (
        input  cmd_valid, cmd_axis, cmd_bank, cmd_activate,
        input  coeff_valid, coeff_data,
        output cmd_ready, coeff_ready,
        output update_en, update_axis, update_bank, update_index, update_value
    );
endinterface

// File: rtl/fir_coeff_loader.sv
// Coefficient load sequencer for the three-axis 16-tap FIR signal path.
// Accepts a load command, streams one bank of coefficients into the signal
// path's write port and optionally switches the axis to the new bank once the
// signal path is idle. Loads into the bank currently in use are refused.
//
// Optional build macro: FIR_COEFF_LOADER_CHECKSUM_EN
//   defined   -> load_sum carries the modulo-2^COEFF_W sum of the last load
//   undefined -> load_sum is tied to zero, no accumulator
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | cmd_ready high, waiting for a load command
// S_LOAD      | coeff_ready high, one write per coefficient handshake
// S_SWAP_WAIT | all taps written, waiting for available to switch bank
// S_DONE      | one-cycle completion pulse, back to S_IDLE next
module fir_coeff_loader #(
    parameter int NUM_TAPS = 16,
    parameter int COEFF_W  = 16
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    fir_coeff_loader_if.slave  bus,
    input  logic               available,
    output logic [1:0]         x_bank,
    output logic [1:0]         y_bank,
    output logic [1:0]         z_bank,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [COEFF_W-1:0] load_sum
);

    localparam int IDX_W = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SWAP_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    logic [1:0]       axis_q;
    logic [1:0]       bank_q;
    logic             act_q;
    logic [IDX_W-1:0] idx_q;

    logic [1:0]       cur_bank;
    logic             cmd_bad;
    logic             cmd_seen;
    logic             cmd_accept;
    logic             coeff_take;

    // Active bank of the requested axis and the command accept/reject decision.
    always_comb begin
        cur_bank = 2'd0;
        case (bus.cmd_axis)
            2'd1:    cur_bank = x_bank;
            2'd2:    cur_bank = y_bank;
            2'd3:    cur_bank = z_bank;
            default: cur_bank = 2'd0;
        endcase
        cmd_bad    = (bus.cmd_axis == 2'd0) || (bus.cmd_bank == cur_bank);
        // cmd_ready is a register that is only high in S_IDLE, so it also
        // keeps the first cycle after reset release from taking a command.
        cmd_seen   = bus.cmd_valid && bus.cmd_ready;
        cmd_accept = cmd_seen && !cmd_bad;
        coeff_take = bus.coeff_valid && bus.coeff_ready;
    end

    // Sequencer: state, handshake readies, write port and bank registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            axis_q           <= 2'd0;
            bank_q           <= 2'd0;
            act_q            <= 1'b0;
            idx_q            <= '0;
            bus.cmd_ready    <= 1'b0;
            bus.coeff_ready  <= 1'b0;
            bus.update_en    <= 1'b0;
            bus.update_axis  <= 2'd0;
            bus.update_bank  <= 2'd0;
            bus.update_index <= '0;
            bus.update_value <= '0;
            x_bank           <= 2'd0;
            y_bank           <= 2'd0;
            z_bank           <= 2'd0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
        end else begin
            bus.update_en <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;

            case (state)
                S_IDLE: begin
                    bus.cmd_ready <= 1'b1;
                    if (cmd_seen) begin
                        if (cmd_bad) begin
                            err <= 1'b1;
                        end else begin
                            axis_q          <= bus.cmd_axis;
                            bank_q          <= bus.cmd_bank;
                            act_q           <= bus.cmd_activate;
                            idx_q           <= '0;
                            bus.cmd_ready   <= 1'b0;
                            bus.coeff_ready <= 1'b1;
                            busy            <= 1'b1;
                            state           <= S_LOAD;
                        end
                    end
                end

                S_LOAD: begin
                    if (coeff_take) begin
                        bus.update_en    <= 1'b1;
                        bus.update_axis  <= axis_q;
                        bus.update_bank  <= bank_q;
                        bus.update_index <= idx_q;
                        bus.update_value <= bus.coeff_data;
                        idx_q            <= idx_q + IDX_W'(1);
                        if (idx_q == LAST_IDX) begin
                            bus.coeff_ready <= 1'b0;
                            if (act_q) begin
                                state <= S_SWAP_WAIT;
                            end else begin
                                done  <= 1'b1;
                                state <= S_DONE;
                            end
                        end
                    end
                end

                S_SWAP_WAIT: begin
                    // The switch must not land mid-filter, so it waits for an
                    // idle signal path with no timeout.
                    if (available) begin
                        case (axis_q)
                            2'd1:    x_bank <= bank_q;
                            2'd2:    y_bank <= bank_q;
                            2'd3:    z_bank <= bank_q;
                            default: ;
                        endcase
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    busy          <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                    state         <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
    logic [COEFF_W-1:0] sum_q;

    // Running modulo-2^COEFF_W sum of the coefficients of the current load.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (cmd_accept) begin
            sum_q <= '0;
        end else if (coeff_take) begin
            sum_q <= sum_q + bus.coeff_data;
        end
    end

    assign load_sum = sum_q;
`else
    logic unused_accept;

    assign unused_accept = cmd_accept;
    assign load_sum      = '0;
`endif

endmodule
